// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add unsigned multiplier, valid/ready both sides, WIDTH-cycle latency
// Define SEQ_MULT_OVF_EN to add the ovf output (product does not fit in WIDTH bits).
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SEQ_MULT_OVF_EN
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
`else
  output logic [2*WIDTH-1:0] product
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_next;
  logic             w_accept;
  logic             w_last_step;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next  = r_acc + w_addend;
  assign w_accept    = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_last_step = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand    <= {{WIDTH{1'b0}}, a};
            r_mplier   <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          // Fixed WIDTH steps: zero operands still walk the full count.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_product   <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;

`ifdef SEQ_MULT_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last_step) begin
      r_ovf <= |w_acc_next[PW-1:WIDTH];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
